button_conditioner: RTL and testbench

Conditions the raw push-button input for the whack-a-mole game controller. It synchronises the asynchronous pad signal, debounces it with a stability counter, and emits a clean level plus single-cycle press and release pulses. The `btn_level` output drives the game controller's `button` input directly. An optional long-press pulse is provided for a future "return to idle" gesture.

---
 rtl/button_conditioner.sv | 158 +++++++++++++++
 tb/tb_button_conditioner.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, four-state debounce FSM, press/release pulses
// and an optional long-press pulse built when BUTTON_CONDITIONER_LONG_PRESS_EN is defined.
//
// state      | meaning
// S_LOW      | stable low
// S_ARM_HIGH | candidate high, counting
// S_HIGH     | stable high
// S_ARM_LOW  | candidate low, counting
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic HOLD_CFG_OK = (HOLD_CYCLES > DEBOUNCE_CYCLES);

  localparam logic [1:0] S_LOW      = 2'd0;
  localparam logic [1:0] S_ARM_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH     = 2'd2;
  localparam logic [1:0] S_ARM_LOW  = 2'd3;

  logic          sync1_q, sync0_q;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync0_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync0_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync0_q) begin
          state_d = S_ARM_HIGH;
          cnt_d   = DB_ONE;
        end
      end
      S_ARM_HIGH: begin
        if (!sync0_q) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      S_HIGH: begin
        if (!sync0_q) begin
          state_d = S_ARM_LOW;
          cnt_d   = DB_ONE;
        end
      end
      S_ARM_LOW: begin
        if (sync0_q) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = S_LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;
  logic          in_hold;

  assign in_hold = (state_q == S_HIGH) || (state_q == S_ARM_LOW);

  // Suppress the pulse on the very edge a release is accepted so it never lands with btn_release.
  always_comb begin
    hold_d = hold_q;
    if (press_d) begin
      hold_d = '0;
    end else if (in_hold && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HW'(1);
    end
    long_d = HOLD_CFG_OK && level_q && in_hold && !release_d && (hold_q == HOLD_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = 1'b0 & HOLD_CFG_OK;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, HOLD_CYCLES=32.
module tb_button_conditioner;

  localparam int DEB  = 8;
  localparam int HOLD = 32;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam logic LONG_EN = 1'b1;
`else
  localparam logic LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_level, btn_press, btn_release, btn_long;

  int checks = 0;
  int errors = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input logic lvl, input logic prs, input logic rel, input logic lng,
                         input string tag);
    chk(btn_level,   lvl, {tag, " level"});
    chk(btn_press,   prs, {tag, " press"});
    chk(btn_release, rel, {tag, " release"});
    chk(btn_long,    lng, {tag, " long"});
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b0;
    repeat (3) tick();
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, "reset");
    reset = 1'b0;
    repeat (5) tick();
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // clean press held 60 cycles: press at 10, long 32 after press
    btn_raw = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      chk_all(i >= 10, i == 10, 1'b0, LONG_EN && (i == 42), $sformatf("clean_press c%0d", i));
    end

    btn_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_all(i < 10, 1'b0, i == 10, 1'b0, $sformatf("release1 c%0d", i));
    end

    btn_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_all(i >= 10, i == 10, 1'b0, 1'b0, $sformatf("press2 c%0d", i));
    end
    btn_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_all(i < 10, 1'b0, i == 10, 1'b0, $sformatf("release2 c%0d", i));
    end

    // bounce: 3-cycle segments, last one low, then settle high
    for (int s = 0; s < 10; s++) begin
      btn_raw = ((s % 2) == 0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk_all(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("bounce s%0d k%0d", s, k));
      end
    end
    btn_raw = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk_all(i >= 10, i == 10, 1'b0, 1'b0, $sformatf("settle c%0d", i));
    end

    // release bounce: 5 low cycles then back high; long lands 32 after the press above
    for (int j = 1; j <= 25; j++) begin
      btn_raw = (j >= 6);
      tick();
      chk_all(1'b1, 1'b0, 1'b0, LONG_EN && (j == 2), $sformatf("rel_bounce c%0d", j));
    end

    btn_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_all(i < 10, 1'b0, i == 10, 1'b0, $sformatf("release3 c%0d", i));
    end

    // reset while S_ARM_HIGH with counter=5
    btn_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_all(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("arm c%0d", i));
    end
    reset = 1'b1;
    #1;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_arm");
    tick();
    tick();
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, "reset_held");
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_all(i >= 10, i == 10, 1'b0, 1'b0, $sformatf("after_reset c%0d", i));
    end

    // reset while high, button still held: treated as a new press
    reset = 1'b1;
    #1;
    chk_all(1'b0, 1'b0, 1'b0, 1'b0, "reset_high");
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_all(i >= 10, i == 10, 1'b0, 1'b0, $sformatf("held_thru_reset c%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
